uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr_arb2.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// timing parameters and a counter-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACC  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int DEF_MAX_FRAME = 16;
  localparam int DEF_BUSY_TO   = 4;
  localparam int DEF_GAP_TO    = 1000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the UART transmit arbiter.
interface uart_tx_arbiter_if;
  // reqN/dataN/lastN are show-ahead: a byte is consumed in exactly the cycle
  // ackN is high; dout is valid only while dout_vld pulses, and the
  // transmitter answers with busy from the following cycle.
  logic       req0;
  logic [7:0] data0;
  logic       last0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       last1;
  logic       ack1;
  logic       busy;
  logic [7:0] dout;
  logic       dout_vld;
  logic [1:0] gnt;
  logic       cut;

  modport slave (
    input  req0, data0, last0, req1, data1, last1, busy,
    output ack0, ack1, dout, dout_vld, gnt, cut
  );

  modport master (
    output req0, data0, last0, req1, data1, last1, busy,
    input  ack0, ack1, dout, dout_vld, gnt, cut
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the source not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] served_i,
  output logic [1:0] gnt_o
);

  // Index of the source served most recently.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && (served_i != 2'b00)) ptr_d = served_i[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte sources, locking the grant for
// a whole frame and pacing bytes against the transmitter busy flag.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int MAX_FRAME = DEF_MAX_FRAME,
  parameter int BUSY_TO   = DEF_BUSY_TO,
  parameter int GAP_TO    = DEF_GAP_TO
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output state_e             state_o
);

  localparam int BW = $clog2(MAX_FRAME + 1);
  localparam int TW = cnt_w(BUSY_TO);
  localparam int GW = cnt_w(GAP_TO);
  localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_FRAME);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TO - 1);

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [7:0]      dout_q, dout_d;
  logic            vld_q, vld_d;
  logic            cut_q, cut_d;
  logic            fend_q, fend_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   to_q, to_d;

  logic       req_g, last_g, ack_g, rel;
  logic [7:0] data_g;
  logic [1:0] arb_gnt;

  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({bus.req1, bus.req0}),
    .upd_i    (rel),
    .served_i (gnt_q),
    .gnt_o    (arb_gnt)
  );

  assign req_g  = (gnt_q[0] & bus.req0) | (gnt_q[1] & bus.req1);
  assign data_g = gnt_q[1] ? bus.data1 : bus.data0;
  assign last_g = gnt_q[1] ? bus.last1 : bus.last0;
  // Never acknowledge while the transmitter is busy, so no byte is dropped.
  assign ack_g  = (state_q == ST_SEND) && req_g && !bus.busy;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    cut_d   = 1'b0;
    fend_d  = fend_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    to_d    = to_q;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = arb_gnt;
          byte_d  = '0;
          gap_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ack_g) begin
          dout_d  = data_g;
          vld_d   = 1'b1;
          if (byte_q != BYTE_MAX) byte_d = byte_q + 1'b1;
          fend_d  = last_g;
          gap_d   = '0;
          to_d    = '0;
          state_d = ST_WAIT_ACC;
        end else if (!req_g) begin
          if (gap_q == GAP_LAST) begin
            cut_d   = 1'b1;
            rel     = 1'b1;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      ST_WAIT_ACC: begin
        // busy lags dout_vld by a cycle; waiting here stops a double issue.
        if (bus.busy || (to_q == TO_LAST)) begin
          to_d    = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.busy) begin
          if (fend_q) begin
            rel     = 1'b1;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end else if (byte_q == BYTE_MAX) begin
            cut_d   = 1'b1;
            rel     = 1'b1;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      cut_q   <= 1'b0;
      fend_q  <= 1'b0;
      byte_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      cut_q   <= cut_d;
      fend_q  <= fend_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  assign bus.ack0     = ack_g & gnt_q[0];
  assign bus.ack1     = ack_g & gnt_q[1];
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.gnt      = gnt_q;
  assign bus.cut      = cut_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: source/transmitter models, scoreboard
// of expected bytes and cut pulses, and cycle-exact latency checks.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int W = 10;  // {is_cut, src, byte}

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .MAX_FRAME (16),
    .BUSY_TO   (4),
    .GAP_TO    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int ack_cnt = 0;
  int vld_cnt = 0;
  int cut_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   src_q0[$];
  logic [8:0]   src_q1[$];
  bit           en0 = 1'b1;
  bit           drop0 = 1'b0;
  int           busy_len = 10;
  int           busy_cnt = 0;
  bit           ack0_s = 1'b0, ack1_s = 1'b0, vld_s = 1'b0;
  logic         last_src = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic sb_compare(input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL sb_unexpected: got %0h with nothing expected at %0t", act, $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_output", act, e);
    end
  endtask

  // ---------------- source and transmitter models ----------------
  always @(posedge clk) begin
    logic [8:0] h0, h1;
    #1;
    if (ack0_s && src_q0.size() > 0) begin
      void'(src_q0.pop_front());
      if (drop0) begin
        en0   = 1'b0;
        drop0 = 1'b0;
      end
    end
    if (ack1_s && src_q1.size() > 0) void'(src_q1.pop_front());
    if (vld_s) busy_cnt = busy_len;
    if (busy_cnt > 0) begin
      bus.busy = 1'b1;
      busy_cnt--;
    end else begin
      bus.busy = 1'b0;
    end
    h0 = (src_q0.size() > 0) ? src_q0[0] : 9'h000;
    h1 = (src_q1.size() > 0) ? src_q1[0] : 9'h000;
    bus.req0  = en0 && (src_q0.size() > 0);
    bus.data0 = h0[7:0];
    bus.last0 = h0[8];
    bus.req1  = (src_q1.size() > 0);
    bus.data1 = h1[7:0];
    bus.last1 = h1[8];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ack0_s = bus.ack0;
    ack1_s = bus.ack1;
    vld_s  = bus.dout_vld;
    if (rst_n) begin
      if (bus.ack0 || bus.ack1) begin
        ack_cnt++;
        check("ack_while_busy", bus.busy, 0);
        check("ack_matches_gnt", {bus.ack1, bus.ack0}, bus.gnt);
      end
      if (bus.dout_vld) begin
        vld_cnt++;
        sb_compare({1'b0, bus.gnt[1], bus.dout});
      end
      if (bus.cut) begin
        cut_cnt++;
        sb_compare({1'b1, last_src, 8'h00});
      end
      if (bus.gnt != 2'b00) last_src = bus.gnt[1];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_src(input int src, input logic [7:0] b, input logic last);
    if (src == 0) src_q0.push_back({last, b});
    else          src_q1.push_back({last, b});
  endtask

  task automatic push_exp(input logic is_cut, input int src, input logic [7:0] b);
    logic s;
    s = (src != 0);
    exp_q.push_back({is_cut, s, b});
  endtask

  task automatic push_frame(input int src, input logic [7:0] first, input int n, input int cut_at);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = first + 8'(i);
      push_src(src, b, (i == n - 1));
      push_exp(1'b0, src, b);
      if (cut_at > 0 && i == cut_at - 1) push_exp(1'b1, src, 8'h00);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},   bus.gnt, 0);
    check({tag, "_dout"},  bus.dout, 0);
    check({tag, "_vld"},   bus.dout_vld, 0);
    check({tag, "_cut"},   bus.cut, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    busy_cnt = 0;
    en0   = 1'b1;
    drop0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(dbg_state == ST_IDLE && src_q0.size() == 0 && src_q1.size() == 0 &&
                           exp_q.size() == 0 && !bus.busy && bus.gnt == 2'b00)) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic wait_gnt(input string name, input logic [1:0] g, input int budget);
    int n;
    n = 0;
    while (n < budget && bus.gnt == 2'b00) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.gnt, g);
  endtask

  task automatic wait_vld(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !bus.dout_vld) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.dout_vld, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0, n;
    bus.req0 = 1'b0; bus.data0 = 8'h00; bus.last0 = 1'b0;
    bus.req1 = 1'b0; bus.data1 = 8'h00; bus.last1 = 1'b0;
    bus.busy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single source, 3-byte frame, 10-cycle transmitter, exact latency.
    busy_len = 10;
    c0 = cut_cnt;
    push_frame(0, 8'h11, 3, 0);
    @(negedge clk);
    check("t1_req_rise", bus.req0, 1);
    check("t1_gnt_n", bus.gnt, 2'b00);
    @(negedge clk);
    check("t1_gnt_n1", bus.gnt, 2'b01);
    check("t1_ack_n1", bus.ack0, 1);
    @(negedge clk);
    check("t1_vld_n2", bus.dout_vld, 1);
    check("t1_dout_n2", bus.dout, 8'h11);
    wait_quiet("t1_drain", 300);
    check("t1_no_cut", cut_cnt - c0, 0);

    // Simultaneous requests after reset: source 0 first, then source 1.
    apply_reset();
    busy_len = 3;
    push_frame(0, 8'h41, 2, 0);
    push_frame(1, 8'h51, 2, 0);
    wait_gnt("t2_first_gnt", 2'b01, 10);
    wait_quiet("t2_drain", 300);
    push_frame(0, 8'h61, 2, 0);
    push_frame(1, 8'h71, 2, 0);
    wait_gnt("t2_second_tie_gnt", 2'b01, 10);
    wait_quiet("t2b_drain", 300);

    // 20-byte frame from source 1: 16 bytes, cut, 4 more under a new grant.
    busy_len = 2;
    c0 = cut_cnt;
    push_frame(1, 8'h80, 20, 16);
    wait_quiet("t3_drain", 1000);
    check("t3_one_cut", cut_cnt - c0, 1);

    // last on the 16th byte ends the frame normally.
    c0 = cut_cnt;
    push_frame(0, 8'hA0, 16, 0);
    wait_quiet("t3b_drain", 1000);
    check("t3b_no_cut", cut_cnt - c0, 0);

    // Transmitter stuck idle: bytes advance on the busy timeout.
    busy_len = 0;
    push_frame(0, 8'hC1, 3, 0);
    wait_vld("t4_first_vld", 20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dout_vld && n < 50);
    check("t4_spacing", n, 6);
    wait_quiet("t4_drain", 300);

    // Source 0 stalls mid-frame; gap timeout cuts and source 1 takes over.
    busy_len = 3;
    drop0 = 1'b1;
    push_src(0, 8'hD1, 1'b0);
    push_src(0, 8'hD2, 1'b1);
    push_exp(1'b0, 0, 8'hD1);
    push_exp(1'b1, 0, 8'h00);
    push_exp(1'b0, 1, 8'hE1);
    wait_gnt("t5_gnt0", 2'b01, 10);
    push_src(1, 8'hE1, 1'b1);
    n = 0;
    c0 = 0;
    while (!bus.cut && n < 100) begin
      if (dbg_state == ST_SEND && !bus.req0) c0++;
      @(negedge clk);
      n++;
    end
    check("t5_cut_seen", bus.cut, 1);
    check("t5_gap_cycles", c0, 8);
    check("t5_gnt_at_cut", bus.gnt, 2'b00);
    @(negedge clk);
    check("t5_gnt1_next", bus.gnt, 2'b10);
    src_q0.delete();
    en0 = 1'b1;
    wait_quiet("t5_drain", 300);

    // Reset while waiting on the transmitter; fresh frame afterwards.
    busy_len = 10;
    push_frame(0, 8'hB1, 3, 0);
    n = 0;
    while (dbg_state != ST_WAIT_DONE && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_wait_done", dbg_state, ST_WAIT_DONE);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t6_async");
    check("t6_bytes_left", exp_q.size(), 2);
    exp_q.delete();
    src_q0.delete();
    busy_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame(0, 8'hF1, 2, 0);
    wait_quiet("t6_drain", 300);

    check("ack_eq_vld", ack_cnt, vld_cnt);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
